aux_run_ctrl: RTL

//  Run/step/breakpoint controller for the core. It sits between the resume button and the core

---
 rtl/aux_run_ctrl_pkg.sv | 16 +
 rtl/aux_run_ctrl_debounce.sv | 67 ++++++
 rtl/aux_run_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/aux_run_ctrl_pkg.sv
// Shared definitions for the run/step/breakpoint controller: state width and state codes.
package aux_run_ctrl_pkg;

  // Width of the exported state code.
  localparam int unsigned RcStBit = 3;

  // Controller states; the encodings are visible on the state output.
  typedef enum logic [RcStBit-1:0] {
    RcStRun   = 3'd0,
    RcStPause = 3'd1,
    RcStStep  = 3'd2,
    RcStHalt  = 3'd3,
    RcStBreak = 3'd4
  } rc_state_e;

endpackage

// File: rtl/aux_run_ctrl_debounce.sv
// Resume button conditioning: 2-flop synchroniser, stability counter, rising-edge pulse.
// A button held through reset must be released and pressed again before a pulse is produced.
module aux_debounce #(
  parameter int unsigned DebounceCnt = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic resume,
  output logic press
);

  localparam int unsigned CntW = (DebounceCnt > 1) ? $clog2(DebounceCnt) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCnt - 1);

  logic [1:0]      sync_q;
  logic [1:0]      prime_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            armed_q, armed_d;
  logic            synced;
  logic            flip;
  logic            accept;

  assign synced = sync_q[1];

  // Synchroniser plus a fill marker telling when sync_q holds real samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      prime_q <= 2'b00;
    end else begin
      sync_q  <= {sync_q[0], resume};
      prime_q <= {prime_q[0], 1'b1};
    end
  end

  // Level changes only after DebounceCnt consecutive samples that differ from it.
  always_comb begin
    flip    = (synced != level_q);
    accept  = flip && (cnt_q == CntMax);
    cnt_d   = '0;
    level_d = level_q;
    if (flip && !accept) begin
      cnt_d = cnt_q + CntW'(1);
    end
    if (accept) begin
      level_d = synced;
    end
    // Arm only once a real released sample is seen, so a held button never fires.
    armed_d = armed_q | (prime_q[1] & ~synced & ~level_q);
    press   = accept & synced & armed_q;
  end

  // Debounce state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/aux_run_ctrl.sv
// Run/step/breakpoint controller between the resume button and the core enable.
// Adds single-step, one PC breakpoint, debounced resume and a saturating breakpoint-stop count.
module aux_run_ctrl
  import aux_run_ctrl_pkg::*;
#(
  parameter int unsigned DebounceCnt  = 4,
  parameter bit          StartRunning = 1'b1,
  parameter int unsigned BpCntBit     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                resume,
  input  logic                step_mode,
  input  logic                bp_en,
  input  logic [31:0]         bp_pc,
  input  logic [31:0]         pc,
  input  logic                halt,
  output logic                en,
  output logic [RcStBit-1:0]  state,
  output logic [BpCntBit-1:0] bp_cnt
);

  localparam rc_state_e ResetState = StartRunning ? RcStRun : RcStPause;

  rc_state_e           state_q, state_d;
  logic                skip_q, skip_d;
  logic [BpCntBit-1:0] bp_cnt_q, bp_cnt_d;
  logic                press;
  logic                halt_m;
  logic                bp_hit;

  aux_debounce #(
    .DebounceCnt(DebounceCnt)
  ) u_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .resume(resume),
    .press (press)
  );

  // skip masks the stop condition that just released us for one enabled cycle.
  assign halt_m = halt & ~skip_q;
  assign bp_hit = bp_en & (pc == bp_pc) & ~skip_q;

  // Next-state, enable, skip and breakpoint count.
  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    bp_cnt_d = bp_cnt_q;
    en       = 1'b0;
    unique case (state_q)
      RcStRun: begin
        en = ~halt_m & ~bp_hit;
        if (halt_m) begin
          state_d = RcStHalt;
        end else if (bp_hit) begin
          state_d = RcStBreak;
          if (bp_cnt_q != '1) begin
            bp_cnt_d = bp_cnt_q + BpCntBit'(1);
          end
        end else if (step_mode) begin
          state_d = RcStPause;
        end
      end
      RcStStep: begin
        en      = 1'b1;
        state_d = step_mode ? RcStPause : RcStRun;
      end
      RcStPause, RcStHalt, RcStBreak: begin
        if (press) begin
          state_d = step_mode ? RcStStep : RcStRun;
          skip_d  = 1'b1;
        end
      end
      default: begin
        state_d = ResetState;
      end
    endcase
    // Stop states never enable, so this clear cannot race the set above.
    if (en) begin
      skip_d = 1'b0;
    end
  end

  // State, skip and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ResetState;
      skip_q   <= 1'b0;
      bp_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      skip_q   <= skip_d;
      bp_cnt_q <= bp_cnt_d;
    end
  end

  assign state  = state_q;
  assign bp_cnt = bp_cnt_q;

endmodule
